pipeline_ctrl: RTL
==================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 CLK  in  1  sole clock; all state updates on rising edge.
REQ-002 RST  in  1  reset, asynchronous, active-high.
REQ-003 ihit  in  1  instruction memory returned the fetch this cycle.
REQ-004 dhit  in  1  data memory completed the MEM-stage access this cycle.
REQ-005 mem_req  in  1  dREN_out_3 | dWEN_out_3 (EX/MEM bar holds a load/store).
REQ-006 ex_dREN  in  1  dREN_out_2 (instruction in EX is a load).
REQ-007 ex_rt  in  5 (regbits_t)  rt_out_2, load destination.
REQ-008 id_rs, id_rt  in  5 each  source fields of instr_out_1.
REQ-009 br_taken  in  1  branch resolved taken in MEM.
REQ-010 halt_id, halt_wb  in  1 each  halt opcode decoded in ID; halt_or_out_4.
REQ-011 pc_en, en_1..en_4  out  1 each  load enables for PC and the four register bars.
REQ-012 flush_1..flush_3  out  1 each  load bubble (all-zero controls) into bars 1..3.
REQ-013 halted  out  1  sticky CPU-halted flag.
REQ-014 stall_cnt  out  32  count of cycles with pc_en=0 since reset, excluding HALTED.

Function
REQ-015 States: RUN, MEMWAIT, DRAIN, HALTED (pctrl_state_t); outputs are combinational from state and inputs.
REQ-016 A bar with flush_n=1 shall also have en_n=1; flush overrides captured data.
REQ-017 Priority, highest first: HALTED, memory wait, branch flush, load-use, halt-in-ID, fetch miss, normal.
REQ-018 HALTED: all en/flush 0, pc_en 0, halted 1; exit only by RST.
REQ-019 Memory wait (mem_req & ~dhit, any non-HALTED state): pc_en and all en_n 0, no flushes; RUN enters MEMWAIT; DRAIN stays DRAIN.
REQ-020 MEMWAIT -> RUN on the cycle dhit=1; that cycle all enables 1, and lower-priority rules still apply.
REQ-021 Branch (br_taken): pc_en 1, all en 1, flush_1..flush_3 1; in DRAIN the halt is squashed and state returns to RUN.
REQ-022 Load-use: ex_dREN & ex_rt!=0 & (ex_rt==id_rs | ex_rt==id_rt) -> pc_en 0, en_1 0, en_2 1 with flush_2 1, en_3/en_4 1; exactly one bubble because the bubble clears ex_dREN.
REQ-023 Halt in ID (RUN, halt_id): pc_en 0, en_1 1 with flush_1 1, later bars advance; RUN -> DRAIN.
REQ-024 DRAIN: pc_en 0, flush_1 1, bars 2..4 advance; DRAIN -> HALTED on halt_wb=1.
REQ-025 Fetch miss (~ihit, RUN): pc_en 0, flush_1 1, en_2..en_4 1.
REQ-026 Normal: pc_en and all en 1, no flushes.
REQ-027 stall_cnt increments by 1 each edge with pc_en=0 and state!=HALTED; wraps at 2^32-1 -> 0.
REQ-028 Simultaneous br_taken and halt_wb are impossible by pipeline order; halt_wb takes precedence if both occur.

Reset
REQ-029 RST=1 forces state RUN, halted 0, stall_cnt 0 immediately, regardless of CLK.
REQ-030 RST asserted mid-MEMWAIT or mid-DRAIN abandons the operation; first post-reset cycle follows the RUN rules.

Structure
REQ-031 pctrl_state_t joins cpu_types_pkg; regbits_t is reused from it.
REQ-032 The load-use comparator is a sub-module named hazard_detect; the FSM and counter stay in pipeline_ctrl.

Verification
REQ-033 ex_dREN=1, ex_rt=5, id_rs=5 -> one cycle pc_en=0, en_1=0, flush_2=1; next cycle with ex_dREN=0 all enables 1.
REQ-034 mem_req=1, dhit=0 for 4 cycles then 1 -> pc_en and all en_n 0 for 4 cycles, 1 on the dhit cycle; stall_cnt +4.
REQ-035 br_taken=1 in RUN -> flush_1..flush_3=1, pc_en=1 for that cycle only.
REQ-036 halt_id=1, halt_wb=1 three cycles later -> DRAIN for 3 cycles, then halted=1 and all enables 0 permanently.
REQ-037 halt_id, then br_taken one cycle later -> state back to RUN, halted stays 0.
REQ-038 RST pulse during MEMWAIT -> state RUN, stall_cnt 0, halted 0 without a clock edge.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index width and the pipeline controller state encoding.
// Pure type/constant package with no logic and no timing of its own.
package cpu_types_pkg;

  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] regbits_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    DRAIN   = 2'd2,
    HALTED  = 2'd3
  } pctrl_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard comparator between the load in EX and the sources of the instruction in ID.
// Purely combinational, zero latency; it never stalls anything itself.
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic     ex_dREN,
  input  regbits_t ex_rt,
  input  regbits_t id_rs,
  input  regbits_t id_rt,
  output logic     load_use
);

  // $zero never carries a real dependency, so a load targeting it is harmless.
  assign load_use = ex_dREN && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: enables and bubble loads are combinational
// from state and inputs; the state and the stall counter update on the rising edge of CLK.
module pipeline_ctrl
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        mem_req,
  input  logic        ex_dREN,
  input  regbits_t    ex_rt,
  input  regbits_t    id_rs,
  input  regbits_t    id_rt,
  input  logic        br_taken,
  input  logic        halt_id,
  input  logic        halt_wb,
  output logic        pc_en,
  output logic        en_1,
  output logic        en_2,
  output logic        en_3,
  output logic        en_4,
  output logic        flush_1,
  output logic        flush_2,
  output logic        flush_3,
  output logic        halted,
  output logic [31:0] stall_cnt
);

  pctrl_state_t state, state_nxt;
  logic         load_use;
  logic         mem_wait;

  hazard_detect u_hazard_detect (
    .ex_dREN  (ex_dREN),
    .ex_rt    (ex_rt),
    .id_rs    (id_rs),
    .id_rt    (id_rt),
    .load_use (load_use)
  );

  assign mem_wait = mem_req && !dhit;

  always_comb begin
    state_nxt = state;
    pc_en     = 1'b0;
    en_1      = 1'b0;
    en_2      = 1'b0;
    en_3      = 1'b0;
    en_4      = 1'b0;
    flush_1   = 1'b0;
    flush_2   = 1'b0;
    flush_3   = 1'b0;
    halted    = (state == HALTED);

    if (state == HALTED) begin
      state_nxt = HALTED;
    end else if (mem_wait) begin
      // Whole pipe freezes; a drain in progress resumes once memory answers.
      if (state == RUN) state_nxt = MEMWAIT;
    end else begin
      en_1 = 1'b1;
      en_2 = 1'b1;
      en_3 = 1'b1;
      en_4 = 1'b1;
      if (state == DRAIN) begin
        if (halt_wb) begin
          flush_1   = 1'b1;
          state_nxt = HALTED;
        end else if (br_taken) begin
          // The halt was on the wrong path: squash it and resume fetching.
          pc_en     = 1'b1;
          flush_1   = 1'b1;
          flush_2   = 1'b1;
          flush_3   = 1'b1;
          state_nxt = RUN;
        end else begin
          flush_1 = 1'b1;
        end
      end else begin
        // RUN, or MEMWAIT on the cycle memory completes: ordinary RUN rules.
        state_nxt = RUN;
        if (br_taken) begin
          pc_en   = 1'b1;
          flush_1 = 1'b1;
          flush_2 = 1'b1;
          flush_3 = 1'b1;
        end else if (load_use) begin
          en_1    = 1'b0;
          flush_2 = 1'b1;
        end else if (halt_id) begin
          flush_1   = 1'b1;
          state_nxt = DRAIN;
        end else if (!ihit) begin
          flush_1 = 1'b1;
        end else begin
          pc_en = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= RUN;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (!pc_en && (state != HALTED)) stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule
